// File: rtl/risc_v_mike_pkg.sv
// Shared types and constants for the risc_v_mike data-memory path.
// The address range check lives here so every user agrees on it.
package risc_v_mike_pkg;

    localparam int DATA_32_W          = 32;
    localparam int REG_ADDR_W         = 32;
    localparam int DATA_MEM_DEPTH_DEF = 16;

    typedef logic [REG_ADDR_W-1:0] t_register_addr;

    typedef enum logic {
        ARB_IDLE,
        ARB_RESP
    } t_arb_state;

    typedef enum logic {
        ARB_PORT_C,
        ARB_PORT_D
    } t_arb_port;

    typedef struct packed {
        t_register_addr         addr;
        logic                   we;
        logic [DATA_32_W-1:0]   wdata;
    } t_mem_req;

    function automatic logic addr_in_range(input t_register_addr addr, input int depth);
        return addr < t_register_addr'(depth);
    endfunction

endpackage

// File: rtl/risc_v_mike_starve_counter.sv
// Saturating wait counter for the low-priority port; limit_hit forces its grant.
module risc_v_mike_starve_counter #(
    parameter int LIMIT = 4,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic limit_hit
);

    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] ONE_V   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < LIMIT_V)) begin
            cnt_d = cnt_q + ONE_V;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign limit_hit = (cnt_q >= LIMIT_V);

endmodule

// File: rtl/risc_v_mike_data_mem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: core port C has
// priority, debug/DMA port D is force-granted after waiting STARVE_LIMIT cycles.
module risc_v_mike_data_mem_arbiter
    import risc_v_mike_pkg::*;
#(
    parameter int DATA_MEM_DEPTH = DATA_MEM_DEPTH_DEF,
    parameter int STARVE_LIMIT   = 4,
    parameter int CNT_W          = 3
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    c_req_valid,
    output logic                    c_req_ready,
    input  t_register_addr          c_req_addr,
    input  logic                    c_req_we,
    input  logic [DATA_32_W-1:0]    c_req_wdata,
    output logic                    c_rsp_valid,
    input  logic                    c_rsp_ready,
    output logic [DATA_32_W-1:0]    c_rsp_rdata,
    output logic                    c_rsp_err,

    input  logic                    d_req_valid,
    output logic                    d_req_ready,
    input  t_register_addr          d_req_addr,
    input  logic                    d_req_we,
    input  logic [DATA_32_W-1:0]    d_req_wdata,
    output logic                    d_rsp_valid,
    input  logic                    d_rsp_ready,
    output logic [DATA_32_W-1:0]    d_rsp_rdata,
    output logic                    d_rsp_err,

    output t_register_addr          data_mem_addr,
    output logic                    data_mem_write,
    output logic [DATA_32_W-1:0]    data_mem_wr_data,
    input  logic [DATA_32_W-1:0]    data_mem_rd_data
);

    t_arb_state             state_d, state_q;
    t_arb_port              owner_d, owner_q;
    logic                   err_d, err_q;
    logic [DATA_32_W-1:0]   rdata_d, rdata_q;

    t_arb_port              grant;
    logic                   grant_vld;
    t_mem_req               req;
    logic                   req_err;
    logic                   starve_hit;
    logic                   d_accept;
    logic                   owner_consumed;

    // Grant is only evaluated in IDLE; reset masks it so nothing is accepted or written.
    always_comb begin
        grant     = ARB_PORT_C;
        grant_vld = 1'b0;
        if (rst && (state_q == ARB_IDLE)) begin
            if (d_req_valid && starve_hit) begin
                grant     = ARB_PORT_D;
                grant_vld = 1'b1;
            end else if (c_req_valid) begin
                grant     = ARB_PORT_C;
                grant_vld = 1'b1;
            end else if (d_req_valid) begin
                grant     = ARB_PORT_D;
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        if (grant == ARB_PORT_D) begin
            req = '{addr: d_req_addr, we: d_req_we, wdata: d_req_wdata};
        end else begin
            req = '{addr: c_req_addr, we: c_req_we, wdata: c_req_wdata};
        end
        req_err = !addr_in_range(req.addr, DATA_MEM_DEPTH);
    end

    assign c_req_ready = grant_vld && (grant == ARB_PORT_C);
    assign d_req_ready = grant_vld && (grant == ARB_PORT_D);
    assign d_accept    = d_req_ready;

    assign data_mem_addr    = grant_vld ? req.addr  : '0;
    assign data_mem_wr_data = grant_vld ? req.wdata : '0;
    assign data_mem_write   = grant_vld && req.we && !req_err;

    assign owner_consumed = (owner_q == ARB_PORT_C) ? c_rsp_ready : d_rsp_ready;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_vld) begin
                    state_d = ARB_RESP;
                    owner_d = grant;
                    err_d   = req_err;
                    rdata_d = (!req.we && !req_err) ? data_mem_rd_data : '0;
                end
            end
            ARB_RESP: begin
                if (owner_consumed) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            owner_q <= ARB_PORT_C;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Both ports see the one registered response; only the owner's valid qualifies it.
    assign c_rsp_valid = (state_q == ARB_RESP) && (owner_q == ARB_PORT_C);
    assign d_rsp_valid = (state_q == ARB_RESP) && (owner_q == ARB_PORT_D);
    assign c_rsp_rdata = rdata_q;
    assign d_rsp_rdata = rdata_q;
    assign c_rsp_err   = err_q;
    assign d_rsp_err   = err_q;

    risc_v_mike_starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .clr       (d_accept),
        .inc       (d_req_valid && !d_accept),
        .limit_hit (starve_hit)
    );

endmodule

// File: tb/tb_risc_v_mike_data_mem_arbiter.sv
// Self-checking bench for the data-memory arbiter: directed scenarios plus
// random traffic, compared against a transaction-level model every cycle.
module tb_risc_v_mike_data_mem_arbiter;
    import risc_v_mike_pkg::*;

    localparam int LIMIT = 4;
    localparam logic [31:0] DEPTH_A = 32'd16;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req_valid, c_req_ready, c_req_we, c_rsp_valid, c_rsp_ready, c_rsp_err;
    logic [31:0] c_req_addr, c_req_wdata, c_rsp_rdata;
    logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_ready, d_rsp_err;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
    logic [31:0] data_mem_addr, data_mem_wr_data, data_mem_rd_data;
    logic        data_mem_write;

    logic [31:0] mem     [16] = '{default: 32'h0};
    logic [31:0] ref_mem [16] = '{default: 32'h0};

    int n_vec = 0;
    int n_err = 0;

    bit          m_busy;
    bit          m_owner_d;
    logic [31:0] m_rdata;
    bit          m_err;
    int          m_wait;
    bit          acc_c, acc_d;

    always #5 clk = ~clk;

    risc_v_mike_data_mem_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .c_req_valid      (c_req_valid),
        .c_req_ready      (c_req_ready),
        .c_req_addr       (c_req_addr),
        .c_req_we         (c_req_we),
        .c_req_wdata      (c_req_wdata),
        .c_rsp_valid      (c_rsp_valid),
        .c_rsp_ready      (c_rsp_ready),
        .c_rsp_rdata      (c_rsp_rdata),
        .c_rsp_err        (c_rsp_err),
        .d_req_valid      (d_req_valid),
        .d_req_ready      (d_req_ready),
        .d_req_addr       (d_req_addr),
        .d_req_we         (d_req_we),
        .d_req_wdata      (d_req_wdata),
        .d_rsp_valid      (d_rsp_valid),
        .d_rsp_ready      (d_rsp_ready),
        .d_rsp_rdata      (d_rsp_rdata),
        .d_rsp_err        (d_rsp_err),
        .data_mem_addr    (data_mem_addr),
        .data_mem_write   (data_mem_write),
        .data_mem_wr_data (data_mem_wr_data),
        .data_mem_rd_data (data_mem_rd_data)
    );

    // Memory model: combinational read, garbage beyond the end so gating is visible.
    assign data_mem_rd_data = (data_mem_addr < DEPTH_A) ? mem[data_mem_addr[3:0]] : 32'h0BAD_0BAD;
    always @(posedge clk) begin
        if (data_mem_write && (data_mem_addr < DEPTH_A)) mem[data_mem_addr[3:0]] <= data_mem_wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: predict from the model, compare, then advance the model across the edge.
    task automatic step();
        bit          e_cr, e_dr, e_acc, e_err, r_we;
        logic [31:0] r_addr, r_wd;
        #2;
        e_cr = 1'b0;
        e_dr = 1'b0;
        if (rst && !m_busy) begin
            if (d_req_valid && m_wait >= LIMIT) e_dr = 1'b1;
            else if (c_req_valid)               e_cr = 1'b1;
            else if (d_req_valid)               e_dr = 1'b1;
        end
        e_acc  = e_cr || e_dr;
        r_addr = e_dr ? d_req_addr  : c_req_addr;
        r_we   = e_dr ? d_req_we    : c_req_we;
        r_wd   = e_dr ? d_req_wdata : c_req_wdata;
        e_err  = (r_addr >= DEPTH_A);

        chk("c_req_ready", {31'b0, c_req_ready}, {31'b0, e_cr});
        chk("d_req_ready", {31'b0, d_req_ready}, {31'b0, e_dr});
        chk("mem_write", {31'b0, data_mem_write}, {31'b0, e_acc && r_we && !e_err});
        chk("mem_addr", data_mem_addr, e_acc ? r_addr : 32'h0);
        chk("mem_wdata", data_mem_wr_data, e_acc ? r_wd : 32'h0);
        chk("c_rsp_valid", {31'b0, c_rsp_valid}, {31'b0, m_busy && !m_owner_d});
        chk("d_rsp_valid", {31'b0, d_rsp_valid}, {31'b0, m_busy && m_owner_d});
        if (m_busy && m_owner_d) begin
            chk("d_rsp_rdata", d_rsp_rdata, m_rdata);
            chk("d_rsp_err", {31'b0, d_rsp_err}, {31'b0, m_err});
        end else if (m_busy) begin
            chk("c_rsp_rdata", c_rsp_rdata, m_rdata);
            chk("c_rsp_err", {31'b0, c_rsp_err}, {31'b0, m_err});
        end
        acc_c = e_cr;
        acc_d = e_dr;

        if (!rst) begin
            m_busy  = 1'b0;
            m_wait  = 0;
            m_rdata = 32'h0;
            m_err   = 1'b0;
        end else begin
            if (e_acc) begin
                m_busy    = 1'b1;
                m_owner_d = e_dr;
                m_err     = e_err;
                m_rdata   = (!r_we && !e_err) ? ref_mem[r_addr[3:0]] : 32'h0;
                if (r_we && !e_err) ref_mem[r_addr[3:0]] = r_wd;
            end else if (m_busy && (m_owner_d ? d_rsp_ready : c_rsp_ready)) begin
                m_busy = 1'b0;
            end
            if (e_dr) m_wait = 0;
            else if (d_req_valid && m_wait < LIMIT) m_wait++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        c_req_valid = 1'b0; c_req_we = 1'b0; c_req_addr = 32'h0; c_req_wdata = 32'h0;
        d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = 32'h0; d_req_wdata = 32'h0;
    endtask

    // Issue one request on a single port, observe its response the cycle after accept, consume it.
    task automatic xact(input bit port_d, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output bit err, output bit vld);
        bit got;
        idle_reqs();
        c_rsp_ready = 1'b1;
        d_rsp_ready = 1'b1;
        if (port_d) begin
            d_req_valid = 1'b1; d_req_we = we; d_req_addr = addr; d_req_wdata = wd;
        end else begin
            c_req_valid = 1'b1; c_req_we = we; c_req_addr = addr; c_req_wdata = wd;
        end
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            got = acc_c || acc_d;
        end
        if (!got) chk("xact_accept", 32'h0, 32'h1);
        idle_reqs();
        vld = port_d ? d_rsp_valid : c_rsp_valid;
        rd  = port_d ? d_rsp_rdata : c_rsp_rdata;
        err = port_d ? d_rsp_err   : c_rsp_err;
        step();
    endtask

    task automatic drain(input int cycles);
        c_rsp_ready = 1'b1;
        d_rsp_ready = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (acc_c) c_req_valid = 1'b0;
            if (acc_d) d_req_valid = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] rd;
        bit          err, vld, got;
        int          order[$];
        int          d_wait;

        m_busy = 1'b0; m_owner_d = 1'b0; m_rdata = 32'h0; m_err = 1'b0; m_wait = 0;
        rst = 1'b0;
        c_rsp_ready = 1'b0;
        d_rsp_ready = 1'b0;
        idle_reqs();

        // Reset held for three edges with both requesters asking.
        c_req_valid = 1'b1; c_req_addr = 32'd0;
        d_req_valid = 1'b1; d_req_addr = 32'd1;
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b1;
        chk("rst_rsp_rdata", c_rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'b0, c_rsp_err}, 32'h0);
        step();
        chk("first_grant_c", {31'b0, acc_c}, 32'h1);
        c_req_valid = 1'b0;
        drain(8);

        // Store then load on the core port.
        xact(1'b0, 1'b1, 32'd3, 32'hDEADBEEF, rd, err, vld);
        chk("c_st_rsp_valid", {31'b0, vld}, 32'h1);
        chk("c_st_rdata", rd, 32'h0);
        xact(1'b0, 1'b0, 32'd3, 32'h0, rd, err, vld);
        chk("c_ld_rsp_valid", {31'b0, vld}, 32'h1);
        chk("c_ld_rdata", rd, 32'hDEADBEEF);
        chk("c_ld_err", {31'b0, err}, 32'h0);

        // Out-of-range store and load on the debug port.
        xact(1'b1, 1'b1, 32'd20, 32'h12345678, rd, err, vld);
        chk("d_oor_st_valid", {31'b0, vld}, 32'h1);
        chk("d_oor_st_err", {31'b0, err}, 32'h1);
        chk("d_oor_st_rdata", rd, 32'h0);
        xact(1'b1, 1'b0, 32'd20, 32'h0, rd, err, vld);
        chk("d_oor_ld_err", {31'b0, err}, 32'h1);
        chk("d_oor_ld_rdata", rd, 32'h0);

        // Both ports continuously valid: expect C,C,D repeating.
        c_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
        c_req_valid = 1'b1; c_req_we = 1'b0; c_req_addr = 32'($urandom_range(0, 15));
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'($urandom_range(0, 15));
        d_wait = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            step();
            if (acc_c) begin
                order.push_back(0);
                c_req_addr = 32'($urandom_range(0, 15));
            end
            if (acc_d) begin
                order.push_back(1);
                chk("d_wait_bound", {31'b0, d_wait <= LIMIT + 1}, 32'h1);
                d_wait = 0;
                d_req_addr = 32'($urandom_range(0, 15));
            end else begin
                d_wait++;
            end
        end
        for (int k = 0; k < order.size(); k++) begin
            chk("grant_order", 32'(order[k]), (k % 3 == 2) ? 32'h1 : 32'h0);
        end
        idle_reqs();
        drain(4);

        // Backpressure on the core response while D waits.
        idle_reqs();
        c_rsp_ready = 1'b0; d_rsp_ready = 1'b1;
        c_req_valid = 1'b1; c_req_addr = 32'd3;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            got = acc_c;
        end
        if (!got) chk("bp_accept", 32'h0, 32'h1);
        c_req_valid = 1'b0;
        d_req_valid = 1'b1; d_req_addr = 32'd5;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_c_valid", {31'b0, c_rsp_valid}, 32'h1);
            chk("bp_c_rdata", c_rsp_rdata, 32'hDEADBEEF);
        end
        drain(6);

        // Reset while a response is pending.
        idle_reqs();
        c_rsp_ready = 1'b0;
        c_req_valid = 1'b1; c_req_addr = 32'd3;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            got = acc_c;
        end
        if (!got) chk("rr_accept", 32'h0, 32'h1);
        c_req_valid = 1'b0;
        rst = 1'b0;
        step();
        chk("rr_rsp_dropped", {31'b0, c_rsp_valid}, 32'h0);
        chk("rr_rdata_clr", c_rsp_rdata, 32'h0);
        rst = 1'b1;
        xact(1'b0, 1'b0, 32'd3, 32'h0, rd, err, vld);
        chk("rr_after_valid", {31'b0, vld}, 32'h1);
        chk("rr_after_rdata", rd, 32'hDEADBEEF);

        // Random traffic on both ports with random response backpressure.
        idle_reqs();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!c_req_valid && $urandom_range(0, 2) != 0) begin
                c_req_valid = 1'b1;
                c_req_we    = 1'($urandom_range(0, 1));
                c_req_addr  = 32'($urandom_range(0, 19));
                c_req_wdata = $urandom;
            end
            if (!d_req_valid && $urandom_range(0, 2) != 0) begin
                d_req_valid = 1'b1;
                d_req_we    = 1'($urandom_range(0, 1));
                d_req_addr  = 32'($urandom_range(0, 19));
                d_req_wdata = $urandom;
            end
            c_rsp_ready = ($urandom_range(0, 3) != 0);
            d_rsp_ready = ($urandom_range(0, 3) != 0);
            step();
            if (acc_c) c_req_valid = 1'b0;
            if (acc_d) d_req_valid = 1'b0;
        end
        idle_reqs();
        drain(4);

        for (int i = 0; i < 16; i++) begin
            chk("mem_final", mem[i], ref_mem[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
